// File: rtl/countdown_seg_driver_pkg.sv
// Shared types and active-low seven-segment patterns (bit 6 = g ... bit 0 = a)
// for the countdown display driver.
package countdown_seg_driver_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] bcd_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Non-decimal codes render as a dash.
module seg7_decode
    import countdown_seg_driver_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        unique case (bcd_t'(bcd_i))
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/countdown_seg_driver.sv
// Multi-channel tick-driven countdown with registered two-digit 7-seg outputs,
// leading-zero blanking and a shared tick-timed blink overlay.
module countdown_seg_driver
    import countdown_seg_driver_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int MAX_CNT    = 99,
    parameter int BLINK_HALF = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [N_CH-1:0]   load,
    input  logic [N_CH*7-1:0] load_val,
    input  logic              blink_en,
    input  logic              blank_lz,
    output logic [N_CH*7-1:0] seg_tens,
    output logic [N_CH*7-1:0] seg_ones,
    output logic [N_CH-1:0]   done
);

    localparam int DIV_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             phase_q, phase_d;
    logic             blank_all;

    always_comb begin
        div_d   = div_q;
        phase_d = phase_q;
        if (!blink_en) begin
            div_d   = '0;
            phase_d = 1'b0;
        end else if (tick) begin
            if (div_q == DIV_W'(BLINK_HALF - 1)) begin
                div_d   = '0;
                phase_d = ~phase_q;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

    assign blank_all = blink_en && phase_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [6:0] lv;
        logic [6:0] cnt_q, cnt_d;
        logic       done_q, done_d;
        bcd_t       tens, ones;
        seg_t       tens_dec, ones_dec;
        seg_t       seg_tens_q, seg_tens_d, seg_ones_q, seg_ones_d;

        assign lv = load_val[i*7 +: 7];

        // A load in the same cycle as a tick suppresses both the decrement and done.
        always_comb begin
            cnt_d  = cnt_q;
            done_d = 1'b0;
            if (load[i]) begin
                cnt_d = (lv > 7'(MAX_CNT)) ? 7'(MAX_CNT) : lv;
            end else if (tick && cnt_q != 7'd0) begin
                cnt_d  = cnt_q - 7'd1;
                done_d = (cnt_q == 7'd1);
            end
        end

        assign tens = 4'(cnt_q / 7'd10);
        assign ones = 4'(cnt_q % 7'd10);

        seg7_decode u_tens (.bcd_i(tens), .seg_o(tens_dec));
        seg7_decode u_ones (.bcd_i(ones), .seg_o(ones_dec));

        always_comb begin
            seg_tens_d = tens_dec;
            seg_ones_d = ones_dec;
            if (blank_lz && tens == 4'd0) begin
                seg_tens_d = SEG_BLANK;
            end
            if (blank_all) begin
                seg_tens_d = SEG_BLANK;
                seg_ones_d = SEG_BLANK;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q      <= 7'd0;
                done_q     <= 1'b0;
                seg_tens_q <= SEG_BLANK;
                seg_ones_q <= SEG_BLANK;
            end else begin
                cnt_q      <= cnt_d;
                done_q     <= done_d;
                seg_tens_q <= seg_tens_d;
                seg_ones_q <= seg_ones_d;
            end
        end

        assign seg_tens[i*7 +: 7] = seg_tens_q;
        assign seg_ones[i*7 +: 7] = seg_ones_q;
        assign done[i]            = done_q;
    end

endmodule

// File: tb/tb_countdown_seg_driver.sv
// Bench for countdown_seg_driver: directed scenarios plus random traffic,
// all compared against a cycle-level arithmetic model of the display.
module tb_countdown_seg_driver;

    localparam int N_CH       = 2;
    localparam int MAX_CNT    = 99;
    localparam int BLINK_HALF = 1;

    logic              clk = 1'b0;
    logic              rst, tick, blink_en, blank_lz;
    logic [N_CH-1:0]   load;
    logic [N_CH*7-1:0] load_val;
    logic [N_CH*7-1:0] seg_tens, seg_ones;
    logic [N_CH-1:0]   done;

    int errors = 0;
    int checks = 0;

    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int                m_cnt [N_CH];
    int                m_div;
    bit                m_phase;
    logic [N_CH*7-1:0] m_tens, m_ones;
    logic [N_CH-1:0]   m_done;

    countdown_seg_driver #(.N_CH(N_CH), .MAX_CNT(MAX_CNT), .BLINK_HALF(BLINK_HALF)) dut (
        .clk(clk), .rst(rst), .tick(tick), .load(load), .load_val(load_val),
        .blink_en(blink_en), .blank_lz(blank_lz),
        .seg_tens(seg_tens), .seg_ones(seg_ones), .done(done)
    );

    always #5 clk = ~clk;

    // Advance one clock; the model consumes the same inputs the DUT saw at the edge.
    task automatic cycle();
        int t, o, lv;
        @(posedge clk);
        for (int ch = 0; ch < N_CH; ch++) begin
            t  = m_cnt[ch] / 10;
            o  = m_cnt[ch] % 10;
            lv = int'(load_val[ch*7 +: 7]);
            if (rst || (blink_en && m_phase)) begin
                m_tens[ch*7 +: 7] = 7'h7F;
                m_ones[ch*7 +: 7] = 7'h7F;
            end else begin
                m_tens[ch*7 +: 7] = (blank_lz && t == 0) ? 7'h7F : pat[t];
                m_ones[ch*7 +: 7] = pat[o];
            end
            m_done[ch] = !rst && tick && !load[ch] && m_cnt[ch] == 1;
            if (rst)                         m_cnt[ch] = 0;
            else if (load[ch])               m_cnt[ch] = (lv > MAX_CNT) ? MAX_CNT : lv;
            else if (tick && m_cnt[ch] > 0)  m_cnt[ch] = m_cnt[ch] - 1;
        end
        if (rst || !blink_en) begin
            m_div   = 0;
            m_phase = 1'b0;
        end else if (tick) begin
            m_div++;
            if (m_div == BLINK_HALF) begin
                m_div   = 0;
                m_phase = !m_phase;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; tick = 1'b0; load = '0; load_val = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 1'b0; load = '0; load_val = '0; blink_en = 1'b0; blank_lz = 1'b0;
        cycle(); cycle();
        checks++;
        if (seg_tens !== {N_CH{7'b1111111}} || seg_ones !== {N_CH{7'b1111111}} || done !== '0) begin
            errors++;
            $display("FAIL reset_blank tens=%h ones=%h done=%b, want all 7f, done 0", seg_tens, seg_ones, done);
        end
        rst = 1'b0;
        cycle();
        checks++;
        if (seg_tens !== {N_CH{7'b1000000}} || seg_ones !== {N_CH{7'b1000000}} || done !== '0) begin
            errors++;
            $display("FAIL reset_release tens=%h ones=%h done=%b, want %h/%h done 0",
                     seg_tens, seg_ones, done, {N_CH{7'b1000000}}, {N_CH{7'b1000000}});
        end
    endtask

    task automatic test_countdown();
        int pulses = 0;
        idle_inputs();
        load = 2'b01; load_val[6:0] = 7'd15;
        cycle();
        idle_inputs();
        cycle();
        checks++;
        if (seg_tens[6:0] !== 7'b1111001 || seg_ones[6:0] !== 7'b0010010) begin
            errors++;
            $display("FAIL countdown_start tens=%b ones=%b, want 1111001/0010010", seg_tens[6:0], seg_ones[6:0]);
        end
        for (int k = 0; k < 15; k++) begin
            for (int ph = 0; ph < 2; ph++) begin
                tick = (ph == 0);
                cycle();
                if (done[0]) pulses++;
                checks++;
                if (seg_tens !== m_tens || seg_ones !== m_ones || done !== m_done) begin
                    errors++;
                    $display("FAIL countdown_step k=%0d tens=%h/%h ones=%h/%h done=%b/%b",
                             k, seg_tens, m_tens, seg_ones, m_ones, done, m_done);
                end
            end
        end
        checks++;
        if (pulses != 1 || seg_tens[6:0] !== 7'b1000000 || seg_ones[6:0] !== 7'b1000000) begin
            errors++;
            $display("FAIL countdown_end pulses=%0d tens=%b ones=%b, want 1 pulse and 00", pulses, seg_tens[6:0], seg_ones[6:0]);
        end
    endtask

    task automatic test_saturate();
        idle_inputs();
        load = 2'b11; load_val = {7'd120, 7'd120};
        cycle();
        idle_inputs();
        cycle();
        checks++;
        if (seg_tens !== {N_CH{7'b0010000}} || seg_ones !== {N_CH{7'b0010000}} || m_cnt[0] != 99) begin
            errors++;
            $display("FAIL saturate tens=%h ones=%h, want 99 on both channels", seg_tens, seg_ones);
        end
    endtask

    task automatic test_load_wins();
        idle_inputs();
        load = 2'b01; load_val[6:0] = 7'd1;
        cycle();
        load_val[6:0] = 7'd30; tick = 1'b1;
        cycle();
        checks++;
        if (done !== 2'b00) begin
            errors++;
            $display("FAIL load_wins_done done=%b, want 00", done);
        end
        idle_inputs();
        cycle();
        checks++;
        if (seg_tens[6:0] !== 7'b0110000 || seg_ones[6:0] !== 7'b1000000 || done !== 2'b00) begin
            errors++;
            $display("FAIL load_wins_val tens=%b ones=%b done=%b, want 30, done 0", seg_tens[6:0], seg_ones[6:0], done);
        end
    endtask

    task automatic test_blank_lz();
        idle_inputs();
        load = 2'b01; load_val[6:0] = 7'd7; blank_lz = 1'b1;
        cycle();
        idle_inputs();
        cycle();
        checks++;
        if (seg_tens[6:0] !== 7'b1111111 || seg_ones[6:0] !== 7'b1111000) begin
            errors++;
            $display("FAIL blank_lz_on tens=%b ones=%b, want 1111111/1111000", seg_tens[6:0], seg_ones[6:0]);
        end
        blank_lz = 1'b0;
        cycle();
        checks++;
        if (seg_tens[6:0] !== 7'b1000000 || seg_ones[6:0] !== 7'b1111000) begin
            errors++;
            $display("FAIL blank_lz_off tens=%b ones=%b, want 1000000/1111000", seg_tens[6:0], seg_ones[6:0]);
        end
    endtask

    task automatic test_blink();
        int blanks = 0;
        idle_inputs();
        load = 2'b11; load_val = {7'd42, 7'd42};
        cycle();
        idle_inputs();
        blink_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick = (k % 2 == 0);
            cycle();
            if (seg_ones[6:0] === 7'h7F) blanks++;
            checks++;
            if (seg_tens !== m_tens || seg_ones !== m_ones || done !== m_done) begin
                errors++;
                $display("FAIL blink k=%0d tens=%h/%h ones=%h/%h done=%b/%b",
                         k, seg_tens, m_tens, seg_ones, m_ones, done, m_done);
            end
        end
        checks++;
        if (blanks == 0 || blanks == 12 || m_cnt[0] != 36) begin
            errors++;
            $display("FAIL blink_alternate blanks=%0d cnt=%0d, want some blanks and count 36", blanks, m_cnt[0]);
        end
        blink_en = 1'b0;
        cycle();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        load = 2'b11; load_val = {7'd5, 7'd5};
        cycle();
        idle_inputs();
        rst = 1'b1; tick = 1'b1;
        cycle();
        checks++;
        if (seg_tens !== {N_CH{7'h7F}} || seg_ones !== {N_CH{7'h7F}} || done !== '0) begin
            errors++;
            $display("FAIL reset_mid tens=%h ones=%h done=%b, want blank and done 0", seg_tens, seg_ones, done);
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            tick = k[0];
            cycle();
            checks++;
            if (seg_tens !== {N_CH{7'b1000000}} || seg_ones !== {N_CH{7'b1000000}} || done !== '0) begin
                errors++;
                $display("FAIL reset_mid_after k=%0d tens=%h ones=%h done=%b, want 00 and done 0", k, seg_tens, seg_ones, done);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            rst  = ($urandom_range(0, 99) == 0);
            tick = ($urandom_range(0, 3) == 0);
            for (int ch = 0; ch < N_CH; ch++) begin
                load[ch]             = ($urandom_range(0, 9) == 0);
                load_val[ch*7 +: 7]  = 7'($urandom_range(0, 127));
            end
            if ($urandom_range(0, 19) == 0) blink_en = ~blink_en;
            if ($urandom_range(0, 9) == 0)  blank_lz = ~blank_lz;
            cycle();
            checks++;
            if (seg_tens !== m_tens || seg_ones !== m_ones || done !== m_done) begin
                errors++;
                $display("FAIL random k=%0d tens=%h/%h ones=%h/%h done=%b/%b",
                         k, seg_tens, m_tens, seg_ones, m_ones, done, m_done);
            end
        end
    endtask

    initial begin
        m_div = 0; m_phase = 1'b0; m_tens = '0; m_ones = '0; m_done = '0;
        for (int ch = 0; ch < N_CH; ch++) m_cnt[ch] = 0;
        test_reset();
        test_countdown();
        test_saturate();
        test_load_wins();
        test_blank_lz();
        test_blink();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/countdown_seg_driver.md
COUNTDOWN_SEG_DRIVER -- requirements
Module: countdown_seg_driver

Interface
REQ-001 Parameter N_CH, default 2: number of independent countdown channels (traffic directions).
REQ-002 Parameter MAX_CNT, default 99, range 1..99: saturation ceiling for loaded values.
REQ-003 Parameter BLINK_HALF, default 1: number of ticks per blink half-period.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port tick, input, 1: one-cycle 1 Hz strobe that gates all decrements and blink timing.
REQ-007 Port load, input, N_CH: per-channel load strobe.
REQ-008 Port load_val, input, N_CH x 7: per-channel binary load value.
REQ-009 Port blink_en, input, 1: global blink mode, used for manual or fault indication.
REQ-010 Port blank_lz, input, 1: blanks the tens digit when it is zero.
REQ-011 Port seg_tens, output, N_CH x 7: active-low tens-digit segments, bit 6 = g ... bit 0 = a.
REQ-012 Port seg_ones, output, N_CH x 7: active-low ones-digit segments, same bit order.
REQ-013 Port done, output, N_CH: one-cycle pulse when a channel count reaches zero by decrement.

Function
REQ-014 Each channel SHALL hold a 7-bit binary count.
REQ-015 load[i]=1 SHALL set count[i] to min(load_val[i], MAX_CNT) on the next edge.
REQ-016 With tick=1, load[i]=0 and count[i]>0, count[i] SHALL decrement by 1.
REQ-017 With count[i]=0, count[i] SHALL hold at 0; no wrap-around.
REQ-018 When load[i] and tick are both 1 in one cycle, load SHALL win: no decrement and no done.
REQ-019 done[i] SHALL pulse high for exactly the one cycle after a tick-driven 1->0 transition.
REQ-020 Loading 0 SHALL NOT assert done.
REQ-021 Each channel SHALL split its count into tens = count/10 and ones = count%10, each 4-bit BCD.
REQ-022 Digit encoding SHALL be active-low, as follows:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any other code = 0111111 (dash)
REQ-023 seg_tens and seg_ones SHALL be registered and reflect the count one cycle after it updates (latency 1).
REQ-024 When blank_lz=1 and tens=0, seg_tens SHALL be 1111111; seg_ones always shows the digit.
REQ-025 A blink divider SHALL count ticks and toggle blink_phase every BLINK_HALF ticks while blink_en=1.
REQ-026 blink_en=0 SHALL clear the blink divider and blink_phase on the next edge.
REQ-027 When blink_en=1 and blink_phase=1, every seg output SHALL be 1111111; counts continue to update.
REQ-028 Channels SHALL be fully independent apart from the shared tick, blink and blank controls.

Reset
REQ-029 rst SHALL be sampled only on the rising clk edge, with priority over all other inputs.
REQ-030 Reset SHALL clear every count to 0, done to 0, blink_phase to 0 and the blink divider to 0.
REQ-031 Reset SHALL drive every seg output to 1111111 (blank).
REQ-032 On the first edge after rst deasserts, seg outputs SHALL show count 0, subject to blank_lz.
REQ-033 Reset asserted mid-countdown SHALL abort the countdown without a done pulse.

Structure
REQ-034 A shared package SHALL hold:
  - the 7-bit segment typedef
  - the ten digit pattern constants, plus SEG_BLANK and SEG_DASH
  - the BCD digit typedef
REQ-035 A combinational sub-module seg7_decode (4-bit BCD in, 7-bit active-low out) SHALL be instantiated 2*N_CH times.
REQ-036 The per-channel counter and BCD split SHALL be generated in a for-generate loop.

Verification
REQ-037 Load 15 on ch0, then apply 15 ticks -> segments step 15..0 ("1","5" down to "0","0"); done[0] pulses once after the 15th tick.
REQ-038 load_val=120 with MAX_CNT=99 -> count 99, seg_tens=seg_ones=0010000.
REQ-039 load=1 and tick=1 in the same cycle with load_val=30, prior count 1 -> count 30, done stays 0.
REQ-040 blank_lz=1 with count 7 -> seg_tens=1111111, seg_ones=1111000; blank_lz=0 -> seg_tens=1000000.
REQ-041 blink_en=1, BLINK_HALF=1, count 42 -> outputs alternate blank/"42" on successive ticks while the count keeps decrementing.
REQ-042 rst asserted at count 5 -> next edge all segs 1111111, done 0; after release, "00" shows with no done pulse.
